// File: rtl/hpm_event_select.sv
// HPM event selector: mhpmevent3..N CSRs, per-counter event routing with privilege
// inhibits, overflow flags and the local counter-overflow interrupt latch.
module hpm_event_select #(
  parameter int XLEN      = 64,
  parameter int COUNTERS  = 32,
  parameter int NUMEVENTS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUMEVENTS-1:0] RawEventM,
  input  logic [1:0]           PrivilegeModeW,
  input  logic                 CSRMWriteM,
  input  logic [11:0]          CSRAdrM,
  input  logic [XLEN-1:0]      CSRWriteValM,
  input  logic [COUNTERS-1:0]  CounterWrapM,
  input  logic                 LCOFIClearM,
  output logic [COUNTERS-1:0]  CounterIncW,
  output logic                 LCOFIrqM,
  output logic [XLEN-1:0]      HPMEventReadValM,
  output logic                 HPMEventHitM
);

  logic [COUNTERS-1:0]      of_q, of_d, minh_q, minh_d, sinh_q, sinh_d, uinh_q, uinh_d;
  logic [COUNTERS-1:0][4:0] sel_q, sel_d;
  logic [COUNTERS-1:0]      inc_q, inc_d;
  logic                     irq_q, irq_d;
  logic [31:0]              raw_pad;
  logic                     mode_m, mode_s, mode_u;
  logic                     unused_bits;

  assign raw_pad = 32'(RawEventM);
  assign mode_m  = (PrivilegeModeW == 2'b11);
  assign mode_s  = (PrivilegeModeW == 2'b01);
  assign mode_u  = (PrivilegeModeW == 2'b00);

  // Flag bits sit at the top of the word in both layouts, only the address differs.
  always_comb begin
    of_d   = of_q;
    minh_d = minh_q;
    sinh_d = sinh_q;
    uinh_d = uinh_q;
    sel_d  = sel_q;
    inc_d  = '0;
    for (int unsigned n = 3; n < COUNTERS; n++) begin
      if (CounterWrapM[n] && !of_q[n]) of_d[n] = 1'b1;
      if (CSRMWriteM && CSRAdrM == 12'(32'h320 + n)) begin
        sel_d[n] = CSRWriteValM[4:0];
        if (XLEN == 64) begin
          of_d[n]   = CSRWriteValM[XLEN-1];
          minh_d[n] = CSRWriteValM[XLEN-2];
          sinh_d[n] = CSRWriteValM[XLEN-3];
          uinh_d[n] = CSRWriteValM[XLEN-4];
        end
      end
      if (XLEN == 32 && CSRMWriteM && CSRAdrM == 12'(32'h720 + n)) begin
        of_d[n]   = CSRWriteValM[XLEN-1];
        minh_d[n] = CSRWriteValM[XLEN-2];
        sinh_d[n] = CSRWriteValM[XLEN-3];
        uinh_d[n] = CSRWriteValM[XLEN-4];
      end
      inc_d[n] = (sel_q[n] != 5'd0) && (32'(sel_q[n]) < NUMEVENTS) && raw_pad[sel_q[n]] &&
                 !((minh_q[n] && mode_m) || (sinh_q[n] && mode_s) || (uinh_q[n] && mode_u));
    end
    // Any 0->1 OF transition (wrap or software) sets the latch and beats a clear.
    irq_d = (|(of_d & ~of_q)) || (irq_q && !LCOFIClearM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_q   <= '0;
      minh_q <= '0;
      sinh_q <= '0;
      uinh_q <= '0;
      sel_q  <= '0;
      inc_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      of_q   <= of_d;
      minh_q <= minh_d;
      sinh_q <= sinh_d;
      uinh_q <= uinh_d;
      sel_q  <= sel_d;
      inc_q  <= inc_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    HPMEventReadValM = '0;
    HPMEventHitM     = 1'b0;
    for (int unsigned n = 3; n < COUNTERS; n++) begin
      if (CSRAdrM == 12'(32'h320 + n)) begin
        HPMEventHitM          = 1'b1;
        HPMEventReadValM[4:0] = sel_q[n];
        if (XLEN == 64) begin
          HPMEventReadValM[XLEN-1] = of_q[n];
          HPMEventReadValM[XLEN-2] = minh_q[n];
          HPMEventReadValM[XLEN-3] = sinh_q[n];
          HPMEventReadValM[XLEN-4] = uinh_q[n];
        end
      end
      if (XLEN == 32 && CSRAdrM == 12'(32'h720 + n)) begin
        HPMEventHitM             = 1'b1;
        HPMEventReadValM[XLEN-1] = of_q[n];
        HPMEventReadValM[XLEN-2] = minh_q[n];
        HPMEventReadValM[XLEN-3] = sinh_q[n];
        HPMEventReadValM[XLEN-4] = uinh_q[n];
      end
    end
  end

  assign CounterIncW = inc_q;
  assign LCOFIrqM    = irq_q;
  assign unused_bits = ^{CSRWriteValM, sel_q[2:0], minh_q[2:0], sinh_q[2:0], uinh_q[2:0],
                         inc_q[2:0], CounterWrapM[2:0]};

endmodule

// File: tb/tb_hpm_event_select.sv
// Directed scoreboard bench for hpm_event_select: a 64-bit default instance,
// a 32-bit instance (8 counters) and a 16-event instance share the stimulus.
module tb_hpm_event_select;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] RawEventM;
  logic [1:0]  PrivilegeModeW;
  logic        CSRMWriteM;
  logic [11:0] CSRAdrM;
  logic [63:0] CSRWriteValM;
  logic [31:0] CounterWrapM;
  logic        LCOFIClearM;

  logic [31:0] inc64, inc16;
  logic [7:0]  inc32;
  logic        irq64, irq32, irq16, hit64, hit32, hit16;
  logic [63:0] rd64, rd16;
  logic [31:0] rd32;

  always #5 clk = ~clk;

  hpm_event_select #(.XLEN(64), .COUNTERS(32), .NUMEVENTS(32)) u64 (
    .clk(clk), .reset(reset), .RawEventM(RawEventM), .PrivilegeModeW(PrivilegeModeW),
    .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM),
    .CounterWrapM(CounterWrapM), .LCOFIClearM(LCOFIClearM), .CounterIncW(inc64),
    .LCOFIrqM(irq64), .HPMEventReadValM(rd64), .HPMEventHitM(hit64));

  hpm_event_select #(.XLEN(32), .COUNTERS(8), .NUMEVENTS(32)) u32 (
    .clk(clk), .reset(reset), .RawEventM(RawEventM), .PrivilegeModeW(PrivilegeModeW),
    .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM[31:0]),
    .CounterWrapM(CounterWrapM[7:0]), .LCOFIClearM(LCOFIClearM), .CounterIncW(inc32),
    .LCOFIrqM(irq32), .HPMEventReadValM(rd32), .HPMEventHitM(hit32));

  hpm_event_select #(.XLEN(64), .COUNTERS(32), .NUMEVENTS(16)) u16 (
    .clk(clk), .reset(reset), .RawEventM(RawEventM[15:0]), .PrivilegeModeW(PrivilegeModeW),
    .CSRMWriteM(CSRMWriteM), .CSRAdrM(CSRAdrM), .CSRWriteValM(CSRWriteValM),
    .CounterWrapM(CounterWrapM), .LCOFIClearM(LCOFIClearM), .CounterIncW(inc16),
    .LCOFIrqM(irq16), .HPMEventReadValM(rd16), .HPMEventHitM(hit16));

  typedef struct {
    string       tag;
    int          kind;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  localparam int K_INC64 = 0, K_IRQ64 = 1, K_RD64 = 2, K_HIT64 = 3, K_IRQ32 = 4,
                 K_RD32 = 5, K_HIT32 = 6, K_INC16 = 7, K_RD16 = 8;

  function automatic logic [63:0] observe(int kind);
    case (kind)
      K_INC64: return {32'd0, inc64};
      K_IRQ64: return {63'd0, irq64};
      K_RD64:  return rd64;
      K_HIT64: return {63'd0, hit64};
      K_IRQ32: return {63'd0, irq32};
      K_RD32:  return {32'd0, rd32};
      K_HIT32: return {63'd0, hit32};
      K_INC16: return {32'd0, inc16};
      K_RD16:  return rd16;
      default: return 'x;
    endcase
  endfunction

  task automatic push_exp(input string tag, input int kind, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [63:0] v);
    CSRMWriteM = 1'b1; CSRAdrM = a; CSRWriteValM = v;
    tick();
    CSRMWriteM = 1'b0;
  endtask

  task automatic rd_at(input logic [11:0] a);
    CSRAdrM = a;
    #1;
  endtask

  initial begin
    reset = 1'b1; RawEventM = '0; PrivilegeModeW = 2'b11; CSRMWriteM = 1'b0;
    CSRAdrM = 12'h324; CSRWriteValM = '0; CounterWrapM = '0; LCOFIClearM = 1'b0;
    tick(); tick();
    push_exp("rst_inc", K_INC64, 64'd0);
    push_exp("rst_irq", K_IRQ64, 64'd0);
    push_exp("rst_rd", K_RD64, 64'd0);
    push_exp("rst_hit", K_HIT64, 64'd1);
    drain();
    reset = 1'b0;
    tick();

    // Basic routing: SEL=5 on counter 4, three event cycles
    csr_wr(12'h324, 64'd5);
    RawEventM = 32'h20;
    push_exp("inc_lat0", K_INC64, 64'd0);
    drain();
    for (int i = 0; i < 3; i++) begin
      tick();
      push_exp("inc_on", K_INC64, 64'h10);
      drain();
    end
    RawEventM = '0;
    tick();
    push_exp("inc_off", K_INC64, 64'd0);
    drain();
    rd_at(12'h324);
    push_exp("rd324", K_RD64, 64'd5);
    push_exp("hit324", K_HIT64, 64'd1);
    drain();

    // MINH inhibit, then S-mode counts
    csr_wr(12'h323, (64'd1 << 62) | 64'd7);
    RawEventM = 32'h80;
    tick();
    push_exp("minh_m", K_INC64, 64'd0);
    drain();
    PrivilegeModeW = 2'b01;
    tick();
    push_exp("minh_s", K_INC64, 64'h8);
    drain();
    RawEventM = '0; PrivilegeModeW = 2'b11;
    tick();

    // Overflow on counter 6
    CounterWrapM = 32'h40;
    tick();
    CounterWrapM = '0;
    rd_at(12'h326);
    push_exp("of6_rd", K_RD64, 64'h8000_0000_0000_0000);
    push_exp("of6_irq", K_IRQ64, 64'd1);
    drain();
    LCOFIClearM = 1'b1;
    tick();
    LCOFIClearM = 1'b0;
    push_exp("clr_irq", K_IRQ64, 64'd0);
    drain();
    CounterWrapM = 32'h40;
    tick();
    CounterWrapM = '0;
    push_exp("rewrap_irq", K_IRQ64, 64'd0);
    drain();

    // Write beats wrap on OF
    CounterWrapM = 32'h40;
    csr_wr(12'h326, 64'd0);
    CounterWrapM = '0;
    rd_at(12'h326);
    push_exp("wr_wins_rd", K_RD64, 64'd0);
    push_exp("wr_wins_irq", K_IRQ64, 64'd0);
    drain();

    CounterWrapM = 32'h80;
    tick();
    CounterWrapM = '0;
    push_exp("of7_irq", K_IRQ64, 64'd1);
    drain();
    csr_wr(12'h327, 64'd0);
    push_exp("sw_of_clr_keeps", K_IRQ64, 64'd1);
    drain();
    LCOFIClearM = 1'b1; CounterWrapM = 32'h20;
    tick();
    LCOFIClearM = 1'b0; CounterWrapM = '0;
    push_exp("set_beats_clr", K_IRQ64, 64'd1);
    drain();
    LCOFIClearM = 1'b1;
    tick();
    LCOFIClearM = 1'b0;
    push_exp("clr2", K_IRQ64, 64'd0);
    push_exp("clr2_32", K_IRQ32, 64'd0);
    drain();
    CounterWrapM = 32'h4;
    tick();
    CounterWrapM = '0;
    push_exp("wrap_lo_ign", K_IRQ64, 64'd0);
    drain();

    // XLEN=32 split registers
    csr_wr(12'h723, 64'h8000_0000);
    push_exp("of_h_irq32", K_IRQ32, 64'd1);
    drain();
    rd_at(12'h723);
    push_exp("rd723", K_RD32, 64'h8000_0000);
    push_exp("hit723", K_HIT32, 64'd1);
    push_exp("hit723_64", K_HIT64, 64'd0);
    push_exp("rd723_64", K_RD64, 64'd0);
    drain();
    rd_at(12'h323);
    push_exp("rd323_32", K_RD32, 64'd7);
    drain();
    rd_at(12'h320);
    push_exp("hit320", K_HIT32, 64'd0);
    push_exp("rd320", K_RD32, 64'd0);
    push_exp("hit320_64", K_HIT64, 64'd0);
    drain();
    rd_at(12'h322);
    push_exp("hit322", K_HIT32, 64'd0);
    push_exp("rd322", K_RD32, 64'd0);
    drain();
    rd_at(12'h728);
    push_exp("hit728", K_HIT32, 64'd0);
    push_exp("rd728", K_RD32, 64'd0);
    drain();

    // SEL beyond NUMEVENTS counts nothing
    csr_wr(12'h324, 64'd0);
    csr_wr(12'h323, 64'd31);
    RawEventM = 32'hFFFF_FFFF;
    tick(); tick();
    push_exp("sel31_n16", K_INC16, 64'd0);
    push_exp("sel31_n32", K_INC64, 64'h8);
    drain();
    rd_at(12'h323);
    push_exp("sel31_rd16", K_RD16, 64'd31);
    drain();

    // Mid-stream asynchronous reset
    #2 reset = 1'b1;
    #1;
    push_exp("arst_inc", K_INC64, 64'd0);
    push_exp("arst_irq32", K_IRQ32, 64'd0);
    push_exp("arst_rd", K_RD64, 64'd0);
    drain();
    tick();
    reset = 1'b0;
    tick();
    push_exp("post_rst_inc", K_INC64, 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
